// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_reg
//  Description : Parametrised universal shift register with free-running
//                single-step operations and Start/Count sequenced shifts.
//  Revision    : 1.0  initial release
// ============================================================================

module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic [2:0]       Mode,
    input  logic             Left_Input,
    input  logic             Right_Input,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    output logic [WIDTH-1:0] Result,
    output logic             Left_Output,
    output logic             Right_Output,
    output logic             Busy,
    output logic             Done
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEQ  = 1'b1;

    localparam logic [2:0] c_MODE_HOLD = 3'd0;
    localparam logic [2:0] c_MODE_SHR  = 3'd1;
    localparam logic [2:0] c_MODE_SHL  = 3'd2;
    localparam logic [2:0] c_MODE_LOAD = 3'd3;
    localparam logic [2:0] c_MODE_ROR  = 3'd4;
    localparam logic [2:0] c_MODE_ROL  = 3'd5;
    localparam logic [2:0] c_MODE_ASR  = 3'd6;
    localparam logic [2:0] c_MODE_CLR  = 3'd7;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_remaining;
    logic [2:0]       r_mode;
    logic             r_done;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [2:0]       w_mode_nxt;
    logic             w_done_nxt;
    logic             w_is_shift_mode;

    function automatic logic [WIDTH-1:0] f_apply(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] load_val,
        input logic             li,
        input logic             ri
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            c_MODE_HOLD: r = v;
            c_MODE_SHR:  r = {li, v[WIDTH-1:1]};
            c_MODE_SHL:  r = {v[WIDTH-2:0], ri};
            c_MODE_LOAD: r = load_val;
            c_MODE_ROR:  r = {v[0], v[WIDTH-1:1]};
            c_MODE_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            c_MODE_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            c_MODE_CLR:  r = '0;
            default:     r = v;
        endcase
        return r;
    endfunction

    // State register: reset abandons any sequence without issuing Done.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= c_IDLE;
            r_result    <= '0;
            r_remaining <= '0;
            r_mode      <= c_MODE_HOLD;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_result    <= w_result_nxt;
            r_remaining <= w_remaining_nxt;
            r_mode      <= w_mode_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_is_shift_mode = (Mode == c_MODE_SHR) || (Mode == c_MODE_SHL) ||
                          (Mode == c_MODE_ROR) || (Mode == c_MODE_ROL) ||
                          (Mode == c_MODE_ASR);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_result_nxt    = r_result;
        w_remaining_nxt = r_remaining;
        w_mode_nxt      = r_mode;
        w_done_nxt      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (Start) begin
                    if (w_is_shift_mode && (Count != c_CNT_ZERO)) begin
                        // Result holds on the accepting edge; steps start next edge.
                        w_state_nxt     = c_SEQ;
                        w_remaining_nxt = Count;
                        w_mode_nxt      = Mode;
                    end else begin
                        if (!(w_is_shift_mode && (Count == c_CNT_ZERO))) begin
                            w_result_nxt = f_apply(Mode, r_result, Data,
                                                   Left_Input, Right_Input);
                        end
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_result_nxt = f_apply(Mode, r_result, Data,
                                           Left_Input, Right_Input);
                end
            end
            c_SEQ: begin
                w_result_nxt    = f_apply(r_mode, r_result, Data,
                                          Left_Input, Right_Input);
                w_remaining_nxt = r_remaining - c_CNT_ONE;
                if (r_remaining == c_CNT_ONE) begin
                    w_state_nxt = c_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        Result       = r_result;
        Left_Output  = r_result[WIDTH-1];
        Right_Output = r_result[0];
        Busy         = (r_state == c_SEQ);
        Done         = r_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_shift_reg
//  Description : Directed, table-driven self-checking bench for the
//                universal shift register (WIDTH=8, CNT_W=4).
//  Revision    : 1.0  initial release
// ============================================================================

module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] Data;
    logic [2:0]       Mode;
    logic             Left_Input;
    logic             Right_Input;
    logic             Start;
    logic [CNT_W-1:0] Count;
    logic [WIDTH-1:0] Result;
    logic             Left_Output;
    logic             Right_Output;
    logic             Busy;
    logic             Done;

    int tests    = 0;
    int failures = 0;

    universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Data         (Data),
        .Mode         (Mode),
        .Left_Input   (Left_Input),
        .Right_Input  (Right_Input),
        .Start        (Start),
        .Count        (Count),
        .Result       (Result),
        .Left_Output  (Left_Output),
        .Right_Output (Right_Output),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]       mode;
        logic [WIDTH-1:0] data;
        logic             li;
        logic             ri;
        logic             start;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] exp_res;
        logic             exp_busy;
        logic             exp_done;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [WIDTH-1:0] er,
                         input logic eb, input logic ed);
        tests++;
        if (Result !== er || Busy !== eb || Done !== ed ||
            Left_Output !== er[WIDTH-1] || Right_Output !== er[0]) begin
            failures++;
            $display("FAIL %s: got res=%h lo=%b ro=%b busy=%b done=%b, expected res=%h lo=%b ro=%b busy=%b done=%b",
                     name, Result, Left_Output, Right_Output, Busy, Done,
                     er, er[WIDTH-1], er[0], eb, ed);
        end
    endtask

    task automatic drive(input logic [2:0] m, input logic [WIDTH-1:0] d,
                         input logic li, input logic ri, input logic st,
                         input logic [CNT_W-1:0] c);
        Mode        = m;
        Data        = d;
        Left_Input  = li;
        Right_Input = ri;
        Start       = st;
        Count       = c;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int n;

        vecs[0]  = '{3'd3, 8'h32, 1'b0, 1'b0, 1'b0, 4'd0, 8'h32, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 8'h99, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h33, 1'b0, 1'b0};
        vecs[3]  = '{3'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0, 8'h33, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h99, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h33, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 8'h90, 1'b0, 1'b0, 1'b0, 4'd0, 8'h90, 1'b0, 1'b0};
        vecs[7]  = '{3'd6, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC8, 1'b0, 1'b0};
        vecs[8]  = '{3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h64, 1'b0, 1'b0};
        vecs[9]  = '{3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hC8, 1'b0, 1'b0};
        vecs[10] = '{3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
        vecs[12] = '{3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 8'hA5, 1'b0, 1'b1};
        vecs[13] = '{3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
        vecs[14] = '{3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0, 1'b1};
        vecs[15] = '{3'd3, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0};

        Reset = 1'b0;
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        check("reset_state", 8'h00, 1'b0, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].mode, vecs[i].data, vecs[i].li, vecs[i].ri,
                  vecs[i].start, vecs[i].count);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_busy,
                  vecs[i].exp_done);
        end

        // Rotate-left sequence from 0x81, three steps.
        drive(3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        tick(); check("rol_accept", 8'h81, 1'b1, 1'b0);
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); check("rol_step1", 8'h03, 1'b1, 1'b0);
        tick(); check("rol_step2", 8'h06, 1'b1, 1'b0);
        tick(); check("rol_step3_done", 8'h0C, 1'b0, 1'b1);
        tick(); check("rol_after", 8'h0C, 1'b0, 1'b0);

        // Arithmetic shift right from 0x90, two steps.
        drive(3'd3, 8'h90, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); check("asr_load", 8'h90, 1'b0, 1'b0);
        drive(3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
        tick(); check("asr_accept", 8'h90, 1'b1, 1'b0);
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); check("asr_step1", 8'hC8, 1'b1, 1'b0);
        tick(); check("asr_step2_done", 8'hE4, 1'b0, 1'b1);
        tick(); check("asr_after", 8'hE4, 1'b0, 1'b0);

        // Sequence with noise on Start/Mode/Data, then back-to-back Start in the Done cycle.
        drive(3'd3, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd0);
        tick(); check("noise_load", 8'h5A, 1'b0, 1'b0);
        drive(3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 4'd4);
        tick(); check("noise_accept", 8'h5A, 1'b1, 1'b0);
        drive(3'd7, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd1);
        tick(); check("noise_step1", 8'hAD, 1'b1, 1'b0);
        drive(3'd3, 8'h00, 1'b1, 1'b1, 1'b0, 4'd7);
        tick(); check("noise_step2", 8'hD6, 1'b1, 1'b0);
        drive(3'd2, 8'h11, 1'b1, 1'b1, 1'b1, 4'd2);
        tick(); check("noise_step3", 8'hEB, 1'b1, 1'b0);
        tick(); check("noise_step4_done", 8'hF5, 1'b0, 1'b1);
        drive(3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1);
        tick(); check("b2b_accept", 8'hF5, 1'b1, 1'b0);
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); check("b2b_step1_done", 8'hEA, 1'b0, 1'b1);
        tick(); check("b2b_after", 8'hEA, 1'b0, 1'b0);

        // Reset in the middle of a long rotate.
        drive(3'd3, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); check("rst_load", 8'h3C, 1'b0, 1'b0);
        drive(3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd10);
        tick(); check("rst_accept", 8'h3C, 1'b1, 1'b0);
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(); check("rst_step1", 8'h1E, 1'b1, 1'b0);
        tick(); check("rst_step2", 8'h0F, 1'b1, 1'b0);
        #2 Reset = 1'b0;
        #1 check("rst_async", 8'h00, 1'b0, 1'b0);
        tick(); check("rst_held", 8'h00, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        tick(); check("rst_released", 8'h00, 1'b0, 1'b0);

        // Count >= WIDTH: logical right shift fills entirely with the serial input.
        drive(3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 4'd9);
        tick(); check("long_accept", 8'h00, 1'b1, 1'b0);
        drive(3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 9) begin
            failures++;
            $display("FAIL long_latency: got %0d step edges, expected 9", n);
        end
        check("long_done", 8'hFF, 1'b0, 1'b1);
        tick(); check("long_after", 8'hFF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

`default_nettype wire
